// File: rtl/priv_pkg.sv
// Shared constants for the machine-mode CSR file and interrupt arbiter:
// CSR addresses, cause codes, pend vector layout, mstatus bits and FSM states.
package priv_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam logic [4:0] CAUSE_MSI        = 5'd3;
    localparam logic [4:0] CAUSE_MTI        = 5'd7;
    localparam logic [4:0] CAUSE_MEI        = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

    // Bit positions inside the compact pend vector {lip, eip, tip, sip}
    localparam int unsigned PEND_MSI   = 0;
    localparam int unsigned PEND_MTI   = 1;
    localparam int unsigned PEND_MEI   = 2;
    localparam int unsigned PEND_LOCAL = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        COOL  = 2'd3
    } irq_state_e;

    // Writable mie bits: MSIE, MTIE, MEIE and one bit per local line from 16
    function automatic logic [31:0] mie_mask(input int unsigned n_local);
        return 32'h0000_0888 | (32'((64'(1) << n_local) - 64'(1)) << 16);
    endfunction

endpackage

// File: rtl/priv_irq_unit_if.sv
// CPU-side bundle: CSR access port plus trap entry/exit and interrupt handshake.
interface priv_irq_unit_if;
    logic [11:0] a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        on_exc_enter;
    logic        on_exc_isint;
    logic [31:0] pc_in;
    logic [3:0]  mcause_code_in;
    logic [31:0] mtval_in;
    logic [31:0] trap_vector_out;
    logic        on_exc_leave;
    logic [31:0] mepc_out;
    logic        interrupt;
    logic        int_reply;

    modport master (
        output a, d, we, on_exc_enter, on_exc_isint, pc_in, mcause_code_in,
               mtval_in, on_exc_leave, int_reply,
        input  spo, trap_vector_out, mepc_out, interrupt
    );

    modport slave (
        input  a, d, we, on_exc_enter, on_exc_isint, pc_in, mcause_code_in,
               mtval_in, on_exc_leave, int_reply,
        output spo, trap_vector_out, mepc_out, interrupt
    );
endinterface

// File: rtl/priv_irq_unit_prio_enc.sv
// Fixed-priority encoder over the compact pend vector:
// MEI, then MSI, then MTI, then local lines in ascending index.
module irq_prio_enc
    import priv_pkg::*;
#(
    parameter  int unsigned N_LOCAL = 4,
    localparam int unsigned PEND_W  = N_LOCAL + 3
) (
    input  logic [PEND_W-1:0] pend,
    output logic              valid,
    output logic [4:0]        cause_id
);

    // Later assignments override earlier ones, so the highest priority goes last
    always_comb begin
        valid    = |pend;
        cause_id = '0;
        for (int i = int'(N_LOCAL) - 1; i >= 0; i--) begin
            if (pend[PEND_LOCAL + i]) cause_id = CAUSE_LOCAL_BASE + 5'(i);
        end
        if (pend[PEND_MTI]) cause_id = CAUSE_MTI;
        if (pend[PEND_MSI]) cause_id = CAUSE_MSI;
        if (pend[PEND_MEI]) cause_id = CAUSE_MEI;
    end

endmodule

// File: rtl/priv_irq_unit.sv
// M-mode trap CSR file with N_LOCAL extra interrupt lines and a fixed-priority
// interrupt issue FSM. Define VECTORED_MTVEC_EN to enable vectored mtvec mode.
module priv_irq_unit
    import priv_pkg::*;
#(
    parameter  int unsigned N_LOCAL     = 4,
    parameter  logic [31:0] RESET_MTVEC = 32'h0,
    localparam int unsigned LIP_W       = (N_LOCAL > 0) ? N_LOCAL : 1,
    localparam int unsigned PEND_W      = N_LOCAL + 3
) (
    input  logic              clk,
    input  logic              rst,
    priv_irq_unit_if.slave    cpu,
    input  logic              eip,
    output logic              eip_reply,
    input  logic              tip,
    input  logic              sip,
    input  logic [LIP_W-1:0]  lip
);

    localparam logic [31:0] MIE_MASK   = mie_mask(N_LOCAL);
    localparam logic [31:0] MTVEC_INIT = {RESET_MTVEC[31:2], 2'b00};

    logic              mstatus_mie_q, mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0]       mie_q, mie_d;
    logic [31:0]       mtvec_q, mtvec_d;
    logic [31:0]       mscratch_q, mscratch_d;
    logic [31:0]       mepc_q, mepc_d;
    logic [31:0]       mcause_q, mcause_d;
    logic [31:0]       mtval_q, mtval_d;
    logic [31:0]       mepc_out_q, mepc_out_d;
    logic [31:0]       trap_vector_q, trap_vector_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              reply_q, reply_d;
    irq_state_e        state_q, state_d;
    logic [4:0]        cause_q, cause_d;
    logic              interrupt_q, interrupt_d;
    logic              eip_reply_q, eip_reply_d;
    logic [31:0]       mip_c;
    logic [31:0]       rdata_c;
    logic              win_valid_c;
    logic [4:0]        win_cause_c;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^cpu.pc_in[1:0];

    irq_prio_enc #(.N_LOCAL(N_LOCAL)) u_prio_enc (
        .pend     (pend_q),
        .valid    (win_valid_c),
        .cause_id (win_cause_c)
    );

    // Live mip view and the enabled-pending vector registered for arbitration
    always_comb begin
        mip_c    = '0;
        mip_c[3]  = sip;
        mip_c[7]  = tip;
        mip_c[11] = eip;
        pend_d   = '0;
        pend_d[PEND_MSI] = sip & mie_q[3];
        pend_d[PEND_MTI] = tip & mie_q[7];
        pend_d[PEND_MEI] = eip & mie_q[11];
        for (int i = 0; i < int'(N_LOCAL); i++) begin
            mip_c[16 + i]          = lip[i];
            pend_d[PEND_LOCAL + i] = lip[i] & mie_q[16 + i];
        end
    end

    // CSR read port
    always_comb begin
        rdata_c = '0;
        case (cpu.a)
            CSR_MSTATUS: begin
                rdata_c                   = MSTATUS_MPP;
                rdata_c[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                rdata_c[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MISA:     rdata_c = MISA_VALUE;
            CSR_MIE:      rdata_c = mie_q;
            CSR_MTVEC:    rdata_c = mtvec_q;
            CSR_MSCRATCH: rdata_c = mscratch_q;
            CSR_MEPC:     rdata_c = mepc_q;
            CSR_MCAUSE:   rdata_c = mcause_q;
            CSR_MTVAL:    rdata_c = mtval_q;
            CSR_MIP:      rdata_c = mip_c;
            default:      rdata_c = '0;
        endcase
    end

    // CSR updates: trap entry beats mret, which beats a software write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (cpu.on_exc_enter) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = {cpu.pc_in[31:2], 2'b00};
            if (cpu.on_exc_isint) begin
                mcause_d = {1'b1, 26'b0, cause_q};
                mtval_d  = '0;
            end else begin
                mcause_d = {1'b0, 27'b0, cpu.mcause_code_in};
                mtval_d  = cpu.mtval_in;
            end
        end else if (cpu.on_exc_leave) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (cpu.we) begin
            case (cpu.a)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = cpu.d[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = cpu.d[MSTATUS_MPIE_BIT];
                end
                CSR_MIE: mie_d = cpu.d & MIE_MASK;
                CSR_MTVEC: begin
`ifdef VECTORED_MTVEC_EN
                    mtvec_d[31:2] = cpu.d[31:2];
                    if (!cpu.d[1]) mtvec_d[1:0] = cpu.d[1:0];
`else
                    mtvec_d = {cpu.d[31:2], 2'b00};
`endif
                end
                CSR_MSCRATCH: mscratch_d = cpu.d;
                CSR_MEPC:     mepc_d     = {cpu.d[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = cpu.d;
                CSR_MTVAL:    mtval_d    = cpu.d;
                default:      ;
            endcase
        end
    end

    // Registered views; the vectored offset applies only while an interrupt is in flight
    always_comb begin
        mepc_out_d    = mepc_q;
        trap_vector_d = {mtvec_q[31:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
        if (mtvec_q[1:0] == 2'b01 && (state_q == ISSUE || state_q == WAIT)) begin
            trap_vector_d = {mtvec_q[31:2], 2'b00} + 32'({cause_q, 2'b00});
        end
`endif
    end

    // Interrupt issue FSM: winner frozen on leaving IDLE, COOL lets the MIE clear land
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        interrupt_d = interrupt_q;
        eip_reply_d = 1'b0;
        reply_d     = cpu.int_reply;
        case (state_q)
            IDLE: begin
                if (mstatus_mie_q && win_valid_c) begin
                    cause_d = win_cause_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                interrupt_d = 1'b1;
                eip_reply_d = (cause_q == CAUSE_MEI);
                state_d     = WAIT;
            end
            WAIT: begin
                if (reply_q) begin
                    interrupt_d = 1'b0;
                    state_d     = COOL;
                end
            end
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_INIT;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mepc_out_q     <= '0;
            trap_vector_q  <= MTVEC_INIT;
            pend_q         <= '0;
            reply_q        <= 1'b0;
            state_q        <= IDLE;
            cause_q        <= '0;
            interrupt_q    <= 1'b0;
            eip_reply_q    <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mepc_out_q     <= mepc_out_d;
            trap_vector_q  <= trap_vector_d;
            pend_q         <= pend_d;
            reply_q        <= reply_d;
            state_q        <= state_d;
            cause_q        <= cause_d;
            interrupt_q    <= interrupt_d;
            eip_reply_q    <= eip_reply_d;
        end
    end

    assign cpu.spo             = rdata_c;
    assign cpu.mepc_out        = mepc_out_q;
    assign cpu.trap_vector_out = trap_vector_q;
    assign cpu.interrupt       = interrupt_q;
    assign eip_reply           = eip_reply_q;

endmodule

// File: tb/tb_priv_irq_unit.sv
// Self-checking bench for priv_irq_unit (N_LOCAL=4, RESET_MTVEC=0); honours VECTORED_MTVEC_EN.
module tb_priv_irq_unit;
    import priv_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       eip, tip, sip;
    logic       eip_reply;
    logic [3:0] lip;

    priv_irq_unit_if cpu_if ();

    priv_irq_unit #(.N_LOCAL(4), .RESET_MTVEC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_if),
        .eip       (eip),
        .eip_reply (eip_reply),
        .tip       (tip),
        .sip       (sip),
        .lip       (lip)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef VECTORED_MTVEC_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    // Reference CSR state, kept as plain architectural fields
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        cpu_if.a = a; cpu_if.d = d; cpu_if.we = 1'b1;
        tick();
        cpu_if.we = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
        cpu_if.a = a;
        #1;
        v = cpu_if.spo;
    endtask

    task automatic wait_irq(input int max, output int n, output bit got);
        n = 0; got = 1'b0;
        while (n < max && !got) begin
            tick();
            n++;
            if (cpu_if.interrupt === 1'b1) got = 1'b1;
        end
    endtask

    // CPU takes the interrupt: acknowledge and enter the trap in the same cycle
    task automatic irq_ack(input logic [31:0] pc);
        cpu_if.int_reply = 1'b1; cpu_if.on_exc_enter = 1'b1;
        cpu_if.on_exc_isint = 1'b1; cpu_if.pc_in = pc;
        tick();
        cpu_if.int_reply = 1'b0; cpu_if.on_exc_enter = 1'b0; cpu_if.on_exc_isint = 1'b0;
    endtask

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return {12'b0, lip, 4'b0, eip, 3'b0, tip, 3'b0, sip, 3'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: m_mie_reg = d & 32'h000F_0888;
            12'h305: begin
                m_mtvec[31:2] = d[31:2];
                if (VECTORED && d[1:0] <= 2'b01) m_mtvec[1:0] = d[1:0];
            end
            12'h340: m_mscratch = d;
            12'h341: m_mepc = d & ~32'h3;
            12'h342: m_mcause = d;
            12'h343: m_mtval = d;
            default: ;
        endcase
    endfunction

    // Highest-priority pending source, from the priority list MEI, MSI, MTI, local 0..3
    function automatic int model_winner(input logic e, input logic t, input logic s,
                                        input logic [3:0] l);
        int order [7] = '{11, 3, 7, 16, 17, 18, 19};
        for (int k = 0; k < 7; k++) begin
            case (order[k])
                11:      if (e) return 11;
                3:       if (s) return 3;
                7:       if (t) return 7;
                default: if (l[order[k] - 16]) return order[k];
            endcase
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, prev_mepc, prev_vec, pc;
        logic [11:0] addrs [11] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'h7C0, 12'h000};
        logic [11:0] ra;
        logic [31:0] rd;
        logic [6:0]  src;
        int op, n, w;
        bit got;

        rst = 1'b1; eip = 0; tip = 0; sip = 0; lip = '0;
        cpu_if.a = '0; cpu_if.d = '0; cpu_if.we = 0; cpu_if.on_exc_enter = 0;
        cpu_if.on_exc_isint = 0; cpu_if.pc_in = '0; cpu_if.mcause_code_in = '0;
        cpu_if.mtval_in = '0; cpu_if.on_exc_leave = 0; cpu_if.int_reply = 0;
        tick(); tick();
        rst = 1'b0;

        csr_read(12'h300, v); check("rst_mstatus", v, 32'h1800);
        csr_read(12'h301, v); check("rst_misa", v, 32'h4000_0100);
        csr_read(12'h304, v); check("rst_mie", v, 32'h0);
        check("rst_mepc_out", cpu_if.mepc_out, 32'h0);
        check("rst_vector", cpu_if.trap_vector_out, 32'h0);
        check("rst_interrupt", 32'(cpu_if.interrupt), 32'h0);
        check("rst_eip_reply", 32'(eip_reply), 32'h0);

        // Randomised CSR traffic, exceptions and mret against the reference model
        m_reset();
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 5));
            ra = addrs[$urandom_range(0, 10)];
            rd = $urandom;
            pc = $urandom;
            cpu_if.a = ra; cpu_if.d = rd; cpu_if.pc_in = pc;
            cpu_if.mcause_code_in = 4'($urandom_range(0, 15));
            cpu_if.mtval_in = $urandom;
            cpu_if.we = (op == 1 || op == 3 || op == 4);
            cpu_if.on_exc_enter = (op == 2 || op == 3);
            cpu_if.on_exc_leave = (op == 4 || op == 5);
            prev_mepc = m_mepc;
            prev_vec = {m_mtvec[31:2], 2'b00};
            tick();
            if (cpu_if.on_exc_enter) begin
                m_mpie = m_mie; m_mie = 0;
                m_mepc = pc & ~32'h3;
                m_mcause = {28'b0, cpu_if.mcause_code_in};
                m_mtval = cpu_if.mtval_in;
            end else if (cpu_if.on_exc_leave) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (cpu_if.we) begin
                m_write(ra, rd);
            end
            check("rand_spo", cpu_if.spo, m_read(ra));
            check("rand_mepc_out", cpu_if.mepc_out, prev_mepc);
            check("rand_vector", cpu_if.trap_vector_out, prev_vec);
        end
        cpu_if.we = 0; cpu_if.on_exc_enter = 0; cpu_if.on_exc_leave = 0;

        // Write-mask table: write, then read back
        tbl.push_back('{12'h305, 32'h0000_2000, 32'h0000_2000});
        tbl.push_back('{12'h300, 32'hFFFF_FFFF, 32'h0000_1888});
        tbl.push_back('{12'h301, 32'hFFFF_FFFF, 32'h4000_0100});
        tbl.push_back('{12'h304, 32'hFFFF_FFFF, 32'h000F_0888});
        tbl.push_back('{12'h340, 32'h1234_5678, 32'h1234_5678});
        tbl.push_back('{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC});
        tbl.push_back('{12'h342, 32'hA5A5_A5A5, 32'hA5A5_A5A5});
        tbl.push_back('{12'h343, 32'h5A5A_5A5A, 32'h5A5A_5A5A});
        tbl.push_back('{12'h344, 32'hFFFF_FFFF, 32'h0000_0000});
        tbl.push_back('{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000});
        tbl.push_back('{12'h305, 32'h0000_1003, 32'h0000_1000});
`ifdef VECTORED_MTVEC_EN
        tbl.push_back('{12'h305, 32'h0000_1001, 32'h0000_1001});
        tbl.push_back('{12'h305, 32'h0000_1002, 32'h0000_1001});
`else
        tbl.push_back('{12'h305, 32'h0000_1001, 32'h0000_1000});
`endif
        tbl.push_back('{12'h300, 32'h0000_0000, 32'h0000_1800});
        tbl.push_back('{12'h304, 32'h0000_0000, 32'h0000_0000});
        foreach (tbl[i]) begin
            csr_write(tbl[i].addr, tbl[i].wdata);
            csr_read(tbl[i].addr, v);
            check($sformatf("tbl_%0d_%h", i, tbl[i].addr), v, tbl[i].exp);
        end

        rst = 1'b1; tick(); rst = 1'b0;
        csr_read(12'h340, v); check("rst2_mscratch", v, 32'h0);
        csr_read(12'h305, v); check("rst2_mtvec", v, 32'h0);
        csr_read(12'h342, v); check("rst2_mcause", v, 32'h0);

        // External + timer together: MEI wins, eip_reply pulses with interrupt
        csr_write(12'h304, 32'h880);
        csr_write(12'h300, 32'h8);
        tip = 1; eip = 1;
        wait_irq(10, n, got);
        check("b_irq_got", 32'(got), 32'h1);
        check("b_latency", 32'(n), 32'd3);
        check("b_eip_reply_on", 32'(eip_reply), 32'h1);
        tick();
        check("b_eip_reply_off", 32'(eip_reply), 32'h0);
        check("b_irq_held", 32'(cpu_if.interrupt), 32'h1);
        irq_ack(32'h0000_1000);
        w = model_winner(1, 1, 0, 4'b0);
        csr_read(12'h342, v); check("b_mcause", v, 32'h8000_0000 | 32'(w));
        csr_read(12'h300, v); check("b_mstatus", v, 32'h1880);
        tick();
        check("b_irq_drop", 32'(cpu_if.interrupt), 32'h0);
        check("b_mepc_out", cpu_if.mepc_out, 32'h0000_1000);
        tick(); tick(); tick();
        check("b_no_rearb", 32'(cpu_if.interrupt), 32'h0);
        tip = 0; eip = 0;

        // Exception with a colliding CSR write, then mret
        csr_write(12'h340, 32'h1111_1111);
        csr_write(12'h300, 32'h8);
        cpu_if.on_exc_enter = 1; cpu_if.on_exc_isint = 0; cpu_if.mcause_code_in = 4'd2;
        cpu_if.mtval_in = 32'hDEAD_BEEF; cpu_if.pc_in = 32'h203;
        cpu_if.we = 1; cpu_if.a = 12'h340; cpu_if.d = 32'h55;
        tick();
        cpu_if.on_exc_enter = 0; cpu_if.we = 0;
        csr_read(12'h341, v); check("e_mepc", v, 32'h200);
        csr_read(12'h343, v); check("e_mtval", v, 32'hDEAD_BEEF);
        csr_read(12'h342, v); check("e_mcause", v, 32'h2);
        csr_read(12'h340, v); check("e_write_dropped", v, 32'h1111_1111);
        csr_read(12'h300, v); check("e_mstatus", v, 32'h1880);
        cpu_if.on_exc_leave = 1; tick(); cpu_if.on_exc_leave = 0;
        csr_read(12'h300, v); check("mret_mstatus", v, 32'h1888);
        csr_write(12'h300, 32'h0);

        // Local line 2 (cause 18), optionally vectored
        csr_write(12'h304, 32'h0004_0000);
        csr_write(12'h305, 32'h0000_1001);
        csr_read(12'h305, v); check("c_mtvec", v, VECTORED ? 32'h1001 : 32'h1000);
        csr_write(12'h300, 32'h8);
        lip = 4'b0100;
        wait_irq(10, n, got);
        check("c_irq_got", 32'(got), 32'h1);
        check("c_latency", 32'(n), 32'd3);
        check("c_eip_reply", 32'(eip_reply), 32'h0);
        check("c_vector", cpu_if.trap_vector_out, VECTORED ? 32'h1048 : 32'h1000);
        irq_ack(32'h0000_3000);
        csr_read(12'h342, v); check("c_mcause", v, 32'h8000_0012);
        tick(); tick();
        lip = 4'b0;
        csr_write(12'h305, 32'h0000_1003);
        csr_read(12'h305, v); check("c_mtvec_warl", v, VECTORED ? 32'h1001 : 32'h1000);

        // No preemption, and a source dropping in WAIT still completes
        csr_write(12'h304, 32'h888);
        csr_write(12'h300, 32'h8);
        tip = 1;
        wait_irq(10, n, got);
        check("p_irq_got", 32'(got), 32'h1);
        eip = 1; tip = 0;
        tick(); tick(); tick();
        check("p_irq_held", 32'(cpu_if.interrupt), 32'h1);
        irq_ack(32'h0000_4000);
        csr_read(12'h342, v); check("p_mcause", v, 32'h8000_0007);
        tick(); tick();
        eip = 0;

        // Random source mixes with every line enabled
        csr_write(12'h304, 32'h000F_0888);
        for (int k = 0; k < 12; k++) begin
            src = 7'($urandom_range(1, 127));
            lip = src[3:0]; sip = src[4]; tip = src[5]; eip = src[6];
            w = model_winner(eip, tip, sip, lip);
            csr_write(12'h300, 32'h8);
            wait_irq(8, n, got);
            check("r_irq_got", 32'(got), 32'h1);
            check("r_eip_reply", 32'(eip_reply), (w == 11) ? 32'h1 : 32'h0);
            check("r_vector", cpu_if.trap_vector_out,
                  VECTORED ? 32'h1000 + 32'(4 * w) : 32'h1000);
            pc = $urandom;
            irq_ack(pc);
            csr_read(12'h342, v); check("r_mcause", v, 32'h8000_0000 | 32'(w));
            csr_read(12'h341, v); check("r_mepc", v, pc & ~32'h3);
            lip = 0; sip = 0; tip = 0; eip = 0;
            tick(); tick();
            check("r_irq_drop", 32'(cpu_if.interrupt), 32'h0);
        end

        // Reset while waiting for the CPU acknowledge
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        tip = 1;
        wait_irq(10, n, got);
        check("w_irq_got", 32'(got), 32'h1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("w_irq_reset", 32'(cpu_if.interrupt), 32'h0);
        csr_read(12'h300, v); check("w_mstatus", v, 32'h1800);
        csr_read(12'h344, v); check("w_mip", v, 32'h80);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_if.interrupt !== 1'b0) n++;
        end
        check("w_no_rearb", 32'(n), 32'd0);
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        wait_irq(8, n, got);
        check("w_rearb", 32'(got), 32'h1);
        irq_ack(32'h0000_5000);
        csr_read(12'h342, v); check("w_mcause", v, 32'h8000_0007);
        tip = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
